// File: rtl/dtcl_afpm_pipe.sv
// DTCL-approximate / exact float32 multiplier, 3 stages, latency 3, 1 op/cycle.
// Backpressure: the whole pipe holds while out_valid_o && !out_ready_i; in_ready_o mirrors it.
module dtcl_afpm_pipe #(
    parameter int E     = 10,
    parameter int A     = 6,
    parameter int K     = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      a_i,
    input  logic [31:0]      b_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      p_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [3:0]       flags_o
);
    localparam int T  = 24 - E - A;
    localparam int CH = A / K;

    if (K < 2 || (K & (K - 1)) != 0 || A < K || (A % K) != 0 || E < 1 || T < 1) begin : g_bad_params
        $error("dtcl_afpm_pipe: illegal E/A/K combination");
    end

    function automatic logic [A-1:0] a_field(input logic [23:0] m);
        return {m[23-E -: A-1], m[24-E-A] | m[23-E-A]};
    endfunction

    // Keep only the leading one of every K-bit chunk.
    function automatic logic [A-1:0] quant(input logic [A-1:0] f);
        logic [A-1:0] q;
        logic         hit;
        q = '0;
        for (int c = 0; c < CH; c++) begin
            hit = 1'b0;
            for (int b = K - 1; b >= 0; b--) begin
                if (f[c*K+b] && !hit) begin
                    q[c*K+b] = 1'b1;
                    hit      = 1'b1;
                end
            end
        end
        return q;
    endfunction

    logic              adv;
    logic              s3_vld_q;
    logic [23:0]       ma, mb;
    logic [A-1:0]      qa, qb;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    logic [23:0]       s1_opa_d, s1_opb_d;
    logic [9:0]        s1_esum_d;
    logic              s1_nan_d, s1_zero_d, s1_apx_d;
    logic              s1_vld_q, s1_sgn_q, s1_nan_q, s1_zero_q, s1_apx_q;
    logic [23:0]       s1_opa_q, s1_opb_q;
    logic [9:0]        s1_esum_q;
    logic [TAG_W-1:0]  s1_tag_q;

    logic [35:0]       s2_pplo_d, s2_pphi_d;
    logic              s2_vld_q, s2_sgn_q, s2_nan_q, s2_zero_q, s2_apx_q;
    logic [35:0]       s2_pplo_q, s2_pphi_q;
    logic [9:0]        s2_esum_q;
    logic [TAG_W-1:0]  s2_tag_q;

    logic [47:0]       prod;
    logic              cin;
    logic [22:0]       sig;
    logic [9:0]        ex;
    logic [31:0]       p_d, p_q;
    logic [3:0]        flags_d, flags_q;
    logic [TAG_W-1:0]  tag_q;
    logic              unused_prod_bits;

    assign adv        = !s3_vld_q || out_ready_i;
    assign in_ready_o = adv;

    // S1: decode, quantize. A DTCL operand is {X, Q, T zeros}, so the 24x24
    // product equals the DTCL product P shifted up by 2T and both modes share S2/S3.
    assign ma     = {|a_i[30:23], a_i[22:0]};
    assign mb     = {|b_i[30:23], b_i[22:0]};
    assign nan_a  = (&a_i[30:23]) && (|a_i[22:0]);
    assign nan_b  = (&b_i[30:23]) && (|b_i[22:0]);
    assign inf_a  = (&a_i[30:23]) && !(|a_i[22:0]);
    assign inf_b  = (&b_i[30:23]) && !(|b_i[22:0]);
    assign zero_a = !(|a_i[30:23]) && !(|a_i[22:0]);
    assign zero_b = !(|b_i[30:23]) && !(|b_i[22:0]);
    assign qa     = quant(a_field(ma));
    assign qb     = quant(a_field(mb));

    assign s1_opa_d  = mode_i ? ma : {ma[23 -: E], qa, {T{1'b0}}};
    assign s1_opb_d  = mode_i ? mb : {mb[23 -: E], qb, {T{1'b0}}};
    assign s1_esum_d = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]} - 10'd127;
    assign s1_nan_d  = nan_a | nan_b | (zero_a & inf_b) | (inf_a & zero_b);
    assign s1_zero_d = zero_a | zero_b;
    assign s1_apx_d  = !mode_i && ((|qa) || (|qb));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q  <= 1'b0;
            s1_sgn_q  <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_apx_q  <= 1'b0;
            s1_opa_q  <= '0;
            s1_opb_q  <= '0;
            s1_esum_q <= '0;
            s1_tag_q  <= '0;
        end else if (adv) begin
            s1_vld_q  <= in_valid_i;
            s1_sgn_q  <= a_i[31] ^ b_i[31];
            s1_nan_q  <= s1_nan_d;
            s1_zero_q <= s1_zero_d;
            s1_apx_q  <= s1_apx_d;
            s1_opa_q  <= s1_opa_d;
            s1_opb_q  <= s1_opb_d;
            s1_esum_q <= s1_esum_d;
            s1_tag_q  <= tag_i;
        end
    end

    // S2: two 24x12 partial products.
    assign s2_pplo_d = {12'd0, s1_opa_q} * {24'd0, s1_opb_q[11:0]};
    assign s2_pphi_d = {12'd0, s1_opa_q} * {24'd0, s1_opb_q[23:12]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_vld_q  <= 1'b0;
            s2_sgn_q  <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_apx_q  <= 1'b0;
            s2_pplo_q <= '0;
            s2_pphi_q <= '0;
            s2_esum_q <= '0;
            s2_tag_q  <= '0;
        end else if (adv) begin
            s2_vld_q  <= s1_vld_q;
            s2_sgn_q  <= s1_sgn_q;
            s2_nan_q  <= s1_nan_q;
            s2_zero_q <= s1_zero_q;
            s2_apx_q  <= s1_apx_q;
            s2_pplo_q <= s2_pplo_d;
            s2_pphi_q <= s2_pphi_d;
            s2_esum_q <= s1_esum_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

    // S3: sum, normalise by one position, truncate, special cases.
    assign prod             = {12'd0, s2_pplo_q} + {s2_pphi_q, 12'd0};
    assign cin              = prod[47];
    assign sig              = cin ? prod[46:24] : prod[45:23];
    assign ex               = s2_esum_q + {9'd0, cin};
    assign unused_prod_bits = ^prod[22:0];

    always_comb begin
        p_d     = {s2_sgn_q, ex[7:0], sig};
        flags_d = {3'b000, s2_apx_q};
        if (s2_nan_q) begin
            p_d        = 32'h7FFF_FFFF;
            flags_d[3] = 1'b1;
        end else if (ex[9] || s2_zero_q) begin
            p_d        = {s2_sgn_q, 31'd0};
            flags_d[1] = 1'b1;
        end else if (ex[8]) begin
            p_d        = {s2_sgn_q, 8'hFF, 23'd0};
            flags_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s3_vld_q <= 1'b0;
            p_q      <= '0;
            flags_q  <= '0;
            tag_q    <= '0;
        end else if (adv) begin
            s3_vld_q <= s2_vld_q;
            p_q      <= p_d;
            flags_q  <= flags_d;
            tag_q    <= s2_tag_q;
        end
    end

    assign out_valid_o = s3_vld_q;
    assign p_o         = p_q;
    assign flags_o     = flags_q;
    assign tag_o       = tag_q;
endmodule

// File: tb/tb_dtcl_afpm_pipe.sv
// Scoreboard bench: default-parameter instance plus an E=12/A=8/K=4 instance on shared stimulus.
module tb_dtcl_afpm_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, mode, out_ready;
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic        ir0, ir1, ov0, ov1;
    logic [31:0] p0, p1;
    logic [3:0]  t0, t1, f0, f1;

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  tag;
        logic [3:0]  fl;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;

    dtcl_afpm_pipe dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir0),
        .a_i(a), .b_i(b), .mode_i(mode), .tag_i(tag), .out_valid_o(ov0),
        .out_ready_i(out_ready), .p_o(p0), .tag_o(t0), .flags_o(f0)
    );

    dtcl_afpm_pipe #(.E(12), .A(8), .K(4), .TAG_W(4)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir1),
        .a_i(a), .b_i(b), .mode_i(mode), .tag_i(tag), .out_valid_o(ov1),
        .out_ready_i(out_ready), .p_o(p1), .tag_o(t1), .flags_o(f1)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, expv);
        end
    endtask

    function automatic longint unsigned qz(input longint unsigned m, input int E, input int A, input int K);
        longint unsigned af, q, v;
        af = (((m >> (25 - E - A)) & ((64'd1 << (A - 1)) - 1)) << 1)
           | (((m >> (24 - E - A)) | (m >> (23 - E - A))) & 64'd1);
        q = 0;
        for (int c = 0; c < A / K; c++) begin
            v = (af >> (c * K)) & ((64'd1 << K) - 1);
            for (int bb = K - 1; bb >= 0; bb--) begin
                if (((v >> bb) & 64'd1) != 0) begin
                    q |= 64'd1 << (c * K + bb);
                    break;
                end
            end
        end
        return q;
    endfunction

    // Returns {flags, p}.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic ex,
                                          input int E, input int A, input int K);
        longint unsigned ma, mb, xa, xb, qa, qb, p, sig;
        int ea, eb, cin, top, pw, e;
        logic s, na, nb, ia, ib, za, zb, apx;
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        ma = {41'd0, x[22:0]};
        mb = {41'd0, y[22:0]};
        if (ea != 0) ma += 64'd1 << 23;
        if (eb != 0) mb += 64'd1 << 23;
        na = (ea == 255) && (x[22:0] != 0);
        nb = (eb == 255) && (y[22:0] != 0);
        ia = (ea == 255) && (x[22:0] == 0);
        ib = (eb == 255) && (y[22:0] == 0);
        za = (ea == 0) && (x[22:0] == 0);
        zb = (eb == 0) && (y[22:0] == 0);
        s = x[31] ^ y[31];
        apx = 1'b0;
        if (ex) begin
            p   = ma * mb;
            cin = int'((p >> 47) & 64'd1);
            sig = (p >> (23 + cin)) & 64'h7FFFFF;
        end else begin
            xa  = ma >> (24 - E);
            xb  = mb >> (24 - E);
            qa  = qz(ma, E, A, K);
            qb  = qz(mb, E, A, K);
            pw  = 2 * (A + E);
            p   = ((xa * xb) << (2 * A)) + ((xa * qb + xb * qa) << A) + qa * qb;
            cin = int'((p >> (pw - 1)) & 64'd1);
            top = (cin != 0) ? pw - 2 : pw - 3;
            sig = (top >= 22) ? ((p >> (top - 22)) & 64'h7FFFFF) : ((p << (22 - top)) & 64'h7FFFFF);
            apx = (qa | qb) != 0;
        end
        e = ea + eb - 127 + cin;
        if (na || nb || (za && ib) || (ia && zb)) return {3'b100, apx, 32'h7FFFFFFF};
        if (e < 0 || za || zb) return {3'b001, apx, s, 31'd0};
        if (e > 255) return {3'b010, apx, s, 8'hFF, 23'd0};
        return {3'b000, apx, s, e[7:0], sig[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int sel;
        v   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel < 9) v[30:23] = 8'(100 + $urandom_range(0, 55));
        if ($urandom_range(0, 7) == 0) v[22:0] = '0;
        return v;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic m, input logic [3:0] t,
                         input logic use_e, input logic [31:0] ep, input logic [3:0] ef);
        int w;
        logic [35:0] r;
        exp_t e;
        w = 0;
        a = x; b = y; mode = m; tag = t; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ir0) break;
            w++;
            if (w > 200) begin
                checks++; errors++;
                $display("FAIL issue_timeout got no in_ready expected accept within 200 cycles");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        r = use_e ? {ef, ep} : model(x, y, m, 10, 6, 2);
        e.p = r[31:0]; e.tag = t; e.fl = r[35:32];
        q0.push_back(e);
        r = model(x, y, m, 12, 8, 4);
        e.p = r[31:0]; e.tag = t; e.fl = r[35:32];
        q1.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic mon_one(input int id, input logic ov, input logic ir, input logic [31:0] p,
                           input logic [3:0] t, input logic [3:0] f);
        exp_t e;
        int n;
        chk($sformatf("in_ready%0d", id), ir, !ov || out_ready);
        if (!ov) return;
        n = (id == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out%0d got %h expected no output", id, p);
            return;
        end
        e = (id == 0) ? q0[0] : q1[0];
        chk($sformatf("p%0d", id), p, e.p);
        chk($sformatf("tag%0d", id), t, e.tag);
        chk($sformatf("flags%0d", id), f, e.fl);
        if (out_ready) begin
            if (id == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            mon_one(0, ov0, ir0, p0, t0, f0);
            mon_one(1, ov1, ir1, p1, t1, f1);
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", ov0, 0);
        chk("rst_p", p0, 0);
        chk("rst_tag", t0, 0);
        chk("rst_flags", f0, 0);
        chk("rst_in_ready", ir0, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(32'h40000000, 32'h40400000, 1'b0, 4'd3, 1'b1, 32'h40C00000, 4'b0000);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ov0) begin lat = i; break; end
        end
        chk("latency", lat, 3);
        @(posedge clk); #1;

        issue(32'h3F803000, 32'h3F800000, 1'b0, 4'd1, 1'b1, 32'h3F802000, 4'b0001);
        issue(32'h3F803000, 32'h3F800000, 1'b1, 4'd2, 1'b1, 32'h3F803000, 4'b0000);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 4'd4, 1'b1, 32'h7FFFFFFF, 4'b1000);
        issue(32'h00000000, 32'h7F800000, 1'b1, 4'd5, 1'b1, 32'h7FFFFFFF, 4'b1000);
        issue(32'h7F000000, 32'h7F000000, 1'b0, 4'd6, 1'b1, 32'h7F800000, 4'b0100);
        issue(32'h00800000, 32'h00800000, 1'b1, 4'd7, 1'b1, 32'h00000000, 4'b0010);
        issue(32'hC0000000, 32'h40000000, 1'b0, 4'd8, 1'b1, 32'hC0800000, 4'b0000);

        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(i + 9), 1'b0, 32'd0, 4'd0);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (ov0 && q0.size() > 2) break;
                end
                rdy_mode = 2;
                @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_out_valid", ov0, 1);
                    chk("stall_in_ready", ir0, 0);
                end
                rdy_mode = 0;
            end
        join
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        chk("stream_drain0", q0.size(), 0);
        #1;

        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(i), 1'b0, 32'd0, 4'd0);
        #1;
        chk("inflight_valid", ov0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ov0, 0);
        chk("async_rst_valid_w", ov1, 0);
        chk("async_rst_p", p0, 0);
        chk("async_rst_in_ready", ir0, 1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_output", ov0, 0);
        end
        @(posedge clk); #1;

        rdy_mode = 1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
            issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 32'd0, 4'd0);
        end
        rdy_mode = 0;
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        chk("final_drain0", q0.size(), 0);
        chk("final_drain1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dtcl_afpm_pipe.md
Name: dtcl_afpm_pipe

Overview:
Pipelined, parametrised successor of the combinational DTCL approximate float32 multiplier. It performs decomposition, truncation and chunk-level leading-one quantization. Each operation carries a runtime mode bit that selects DTCL-approximate or exact significand multiplication, a pass-through tag, and valid/ready handshakes on both sides. It sits between an accelerator operand fetch unit and the result writeback path in the SoC frame.

Parameters:
E, 10, exact significand bits (the MSBs of the 24-bit significand, hidden bit included)
A, 6, approximate bits following E; A % K must be 0 (elaboration-time assertion)
K, 2, chunk size in bits; K must be ≥ 2 and a power of two
TAG_W, 4, width of the user tag carried alongside each operation
(derived, not overridable) T = 24-E-A truncated bits; CH = A/K chunks; PW = 2*(A+E) product width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  block can accept an operand pair
a_i  in  32  float32 multiplier
b_i  in  32  float32 multiplicand
mode_i  in  1  0 = DTCL approximate, 1 = exact 24x24
tag_i  in  TAG_W  user tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts the result
p_o  out  32  float32 product
tag_o  out  TAG_W  tag belonging to p_o
flags_o  out  4  {nan, inf, zero, approx}; approx = 1 when mode was 0 and at least one A-region chunk was non-zero

Behaviour:
- Reset (async assert, sync deassert by the system): all stage valids are 0. out_valid_o, p_o, tag_o and flags_o are 0. in_ready_o is 1 after reset.
- Pipeline: 3 stages. S1 decodes and quantizes. S2 forms the partial products. S3 sums, normalises and applies special cases. Latency is 3 cycles from accept to out_valid_o with no backpressure. Throughput is 1 operation per cycle.
- Stall: adv = !out_valid_o || out_ready_i. in_ready_o = adv. When adv = 0, every stage holds, including data and tag. An accept happens when in_valid_i && in_ready_o. Bubbles propagate as invalid stages. Output data must remain stable while out_valid_o && !out_ready_i.
- Reset asserted mid-operation: all in-flight operations are discarded, with no partial output.
- Decode: hidden bit = (exp != 0). NaN = exp 0xFF and sig != 0. Inf = exp 0xFF and sig == 0. Zero = exp 0 and sig 0.
- DTCL mode, per operand with full significand m[23:0]:
  - X = m[23:24-E].
  - The A-field is m[23-E:25-E-A] concatenated with (m[24-E-A] | m[23-E-A]). The A-field LSB ORs in the T MSB; the remaining T bits are dropped.
  - Each K-bit chunk is replaced by a one-hot of its leading one, or zero if the chunk is zero. The result is Q, which is A bits wide.
  - P = (Xa*Xb << 2A) + ((Xa*Qb + Xb*Qa) << A) + Qa*Qb, computed in PW bits.
  - Normalise: if P[PW-1] = 1, then cin = 1 and sig = P[PW-2 -: 23]. Otherwise cin = 0 and sig = P[PW-3 -: 23]. Pad with LSB zeros if PW-2 < 23.
- Exact mode: P = ma*mb in 48 bits. If P[47] = 1, then cin = 1 and sig = P[46:24]. Otherwise cin = 0 and sig = P[45:23]. The result is truncated, with no rounding.
- Exponent: {uf, c, e[7:0]} = ea + eb - 127 + cin, computed in 10 bits.
- Priority in S3:
  1. NaN (either operand NaN, or zero × inf): p = 0x7FFFFFFF, flag nan.
  2. uf, or either operand zero: p = {s, 0x00, 0}, flag zero.
  3. c: p = {s, 0xFF, 0}, flag inf.
  4. Otherwise p = {s, e, sig}, where s = sa ^ sb.
- Subnormal inputs have hidden bit 0 and are otherwise treated like normal inputs. No subnormal outputs are produced.
- Mode and tag are sampled at accept and travel with the operation. Mixed modes back-to-back are legal.

Test Plan:
- 0x40000000 × 0x40400000, mode 0, tag 3, out_ready held 1 → p_o = 0x40C00000, tag_o = 3, flags 0000, out_valid_o exactly 3 cycles after accept.
- 0x3F803000 × 0x3F800000: mode 0 → 0x3F802000, flags approx = 1. mode 1 → 0x3F803000, approx = 0.
- Back-to-back stream of 6 ops with out_ready_i low for 4 cycles mid-stream → in_ready_o = 0 during the stall, no loss or duplication, results in order with matching tags, p_o stable while stalled.
- Special cases:
  - 0x7FC00000 × 0x3F800000 → 0x7FFFFFFF, nan.
  - 0x00000000 × 0x7F800000 → 0x7FFFFFFF, nan.
  - 0x7F000000 × 0x7F000000 → 0x7F800000, inf.
  - 0x00800000 × 0x00800000 → 0x00000000, zero.
  - 0xC0000000 × 0x40000000 → 0xC0800000.
- rst_ni pulsed low with 3 ops in flight → out_valid_o drops immediately and asynchronously, no stale results appear after release, in_ready_o = 1.
- Random 10k operands with K = 3/A = 6 rejected at elaboration; E = 12, A = 8, K = 4 run against a reference model → bit-exact match in both modes.
